// File: rtl/pipe_temp_monitor.sv
// Multi-channel pipe temperature monitor: scans N_CH sensors through one muxed
// ADC every SAMPLE_TICKS minute-ticks, keeps per-channel hysteresis alarms and a
// latched shutdown that trips after PERSIST consecutive over-limit samples.
module pipe_temp_monitor #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned SAMPLE_TICKS = 16,
    parameter int unsigned SETTLE_CYC   = 3,
    parameter int unsigned ALARM_TH     = 80,
    parameter int unsigned HYST         = 5,
    parameter int unsigned SHUT_TH      = 100,
    parameter int unsigned PERSIST      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [DATA_W-1:0]        adc,
    input  logic                     shutdown_clr,
    output logic [$clog2(N_CH)-1:0]  ch_sel,
    output logic                     busy,
    output logic                     scan_done,
    output logic [N_CH*DATA_W-1:0]   temp_bus,
    output logic [N_CH-1:0]          alarm_vec,
    output logic                     alarm,
    output logic                     shutdown,
    output logic                     overrun
);

    localparam int unsigned ChW    = $clog2(N_CH);
    localparam int unsigned TickW  = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int unsigned SetW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned PerW   = $clog2(PERSIST + 1);

    localparam logic [TickW-1:0]  TickLast  = TickW'(SAMPLE_TICKS - 1);
    localparam logic [SetW-1:0]   SetLast   = SetW'(SETTLE_CYC - 1);
    localparam logic [ChW-1:0]    ChLast    = ChW'(N_CH - 1);
    localparam logic [PerW-1:0]   PerMax    = PerW'(PERSIST);
    localparam logic [DATA_W-1:0] AlarmSet  = DATA_W'(ALARM_TH);
    // Clear level computed at elaboration so it can never wrap at run time.
    localparam logic [DATA_W-1:0] AlarmClr  = DATA_W'(ALARM_TH - HYST);
    localparam logic [DATA_W-1:0] ShutLevel = DATA_W'(SHUT_TH);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TickW-1:0]       tick_cnt_q;
    logic                   start_req;
    logic [ChW-1:0]         ch_q, ch_d;
    logic [SetW-1:0]        settle_q, settle_d;
    logic                   capture;
    logic [N_CH*DATA_W-1:0] temp_q, temp_d;
    logic [N_CH-1:0]        alarm_q, alarm_d;
    logic [PerW-1:0]        pers_q [N_CH];
    logic [PerW-1:0]        pers_d [N_CH];
    logic                   shut_q, shut_d;
    logic                   ovr_q, ovr_d;
    logic                   any_trip, all_zero;

    assign start_req = tick && (tick_cnt_q == TickLast);

    // Minute-tick counter; runs in every state and wraps on the start request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= start_req ? '0 : tick_cnt_q + TickW'(1);
        end
    end

    // Scan sequencer next state: settle each channel, capture, then pulse done.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    ch_d     = '0;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == SetLast) begin
                    state_d = StCapture;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StCapture: begin
                capture  = 1'b1;
                settle_d = '0;
                if (ch_q == ChLast) begin
                    state_d = StDone;
                end else begin
                    ch_d    = ch_q + ChW'(1);
                    state_d = StSettle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Per-channel sample, hysteresis alarm, persist counter and shutdown latch.
    always_comb begin
        temp_d   = temp_q;
        alarm_d  = alarm_q;
        any_trip = 1'b0;
        all_zero = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            pers_d[k] = pers_q[k];
            if (capture && ch_q == ChW'(k)) begin
                temp_d[k*DATA_W +: DATA_W] = adc;
                if (adc > AlarmSet) begin
                    alarm_d[k] = 1'b1;
                end else if (adc <= AlarmClr) begin
                    alarm_d[k] = 1'b0;
                end
                if (adc > ShutLevel) begin
                    if (pers_q[k] != PerMax) pers_d[k] = pers_q[k] + PerW'(1);
                end else begin
                    pers_d[k] = '0;
                end
            end
            if (pers_d[k] == PerMax) any_trip = 1'b1;
            if (pers_q[k] != '0)     all_zero = 1'b0;
        end
        // Set wins over a simultaneous clear; clear only with all counters idle.
        if (any_trip) begin
            shut_d = 1'b1;
        end else if (shutdown_clr && all_zero) begin
            shut_d = 1'b0;
        end else begin
            shut_d = shut_q;
        end
        ovr_d = ovr_q | (start_req && (state_q != StIdle));
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            settle_q <= '0;
            temp_q   <= '0;
            alarm_q  <= '0;
            shut_q   <= 1'b0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < N_CH; k++) pers_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            settle_q <= settle_d;
            temp_q   <= temp_d;
            alarm_q  <= alarm_d;
            shut_q   <= shut_d;
            ovr_q    <= ovr_d;
            for (int k = 0; k < N_CH; k++) pers_q[k] <= pers_d[k];
        end
    end

    assign ch_sel    = ch_q;
    assign busy      = (state_q != StIdle);
    assign scan_done = (state_q == StDone);
    assign temp_bus  = temp_q;
    assign alarm_vec = alarm_q;
    assign alarm     = |alarm_q;
    assign shutdown  = shut_q;
    assign overrun   = ovr_q;

endmodule
